iddr_ctl_rx: RTL and testbench
==============================

Name: iddr_ctl_rx

Overview:
Generic input-DDR receive block, the capture-side counterpart of the team's output DDR flip-flop. It samples a DDR data bus plus a DDR control line on both clock edges and realigns each rising/falling pair onto the rising edge. From the control pair it decodes data-valid/error (RGMII-style encoding) and tracks frame boundaries and length. It sits directly behind the input pads of source-synchronous receive paths (e.g. RGMII RX), feeding MAC receive logic.

Parameters:
WIDTH, 4, data bits captured per clock edge; output word is 2*WIDTH bits.
LEN_WIDTH, 16, width of the frame-length counter in output words.

Ports:
clk  input  1  receive clock; both edges used for capture, all outputs on the rising edge.
rst_n  input  1  synchronous active-low reset.
d  input  WIDTH  DDR data from pads.
ctl  input  1  DDR control from pads: rising-edge sample = dv, falling-edge sample = dv XOR er.
q1  output  WIDTH  data sampled on the rising edge.
q2  output  WIDTH  data sampled on the following falling edge.
data_out  output  2*WIDTH  {q2, q1}; low half is the earlier sample.
data_valid  output  1  decoded dv for the current data_out.
data_error  output  1  decoded er for the current data_out (rise XOR fall of ctl).
frame_start  output  1  one-cycle pulse with the first valid word of a frame.
frame_end  output  1  one-cycle pulse on the first non-valid cycle after a frame.
frame_len  output  LEN_WIDTH  word count of the completed frame; held until the next frame_end.
frame_bad  output  1  at frame_end: an error was seen in the frame, or the length saturated; held with frame_len.

Behaviour:
- Capture: rise_reg <= {ctl,d} on posedge; fall_reg <= {ctl,d} on negedge. On posedge k+1: q1 <= rise_reg (sampled at edge k); q2 <= fall_reg (sampled at the negedge between k and k+1).
- Latency: a pair whose first sample is taken at posedge k is visible on q1/q2/data_out after posedge k+1. data_valid and data_error are aligned with that same pair.
- Decode: data_valid = ctl_rise; data_error = ctl_rise ^ ctl_fall. Both are registered with q1/q2, not combinational from the pads.
- Reset, rst_n sampled low at posedge: all posedge registers and outputs go to 0, state = IDLE, counter = 0.
- Reset, rst_n sampled low at negedge: fall_reg clears to 0.
- Reset is synchronous only; there is no asynchronous path.
- FSM, states IDLE and FRAME, evaluated on the registered data_valid/data_error:
  - IDLE with data_valid=1: go to FRAME; frame_start=1; count=1; bad = data_error.
  - IDLE with data_valid=0: stay in IDLE. Errors here are carrier-extension/false-carrier; they are reported on data_error only and do not affect frame state.
  - FRAME with data_valid=1: count += 1, saturating at 2^LEN_WIDTH-1; bad |= data_error; bad |= 1 if saturation is hit.
  - FRAME with data_valid=0: frame_end=1; frame_len <= count; frame_bad <= bad; go to IDLE.
- Pulse timing: frame_start is coincident with the first valid data_out. frame_end is one cycle after the last valid data_out.
- Back-to-back frames: a single-cycle dv gap produces frame_end then frame_start on consecutive cycles. A zero-cycle gap is one frame.
- Reset mid-frame: the frame is abandoned with no frame_end pulse. frame_len and frame_bad clear to 0.

Decomposition:
- No shared package needed. The FSM state encoding (IDLE=0, FRAME=1) is a local parameter.
- Natural sub-module: iddr, a generic WIDTH-bit input DDR cell with q1/q2 realignment. Instantiate it once with WIDTH+1 bits (data + ctl). The framing FSM stays in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while toggling d/ctl -> all outputs 0 after the first posedge; no frame_start.
- Alignment, WIDTH=4: drive d=0x5 at rise and 0xA at fall, then 0x3/0xC -> data_out=0xA5 one cycle later, then 0xC3; q1=0x5, q2=0xA.
- Clean frame: ctl=1/1 for 64 cycles, then 0/0 -> frame_start with the first word; frame_end 1 cycle after the last; frame_len=64; frame_bad=0.
- Error in frame: ctl=1/0 on word 10 of a 20-word frame -> data_error=1 on that word; frame_len=20; frame_bad=1. Separately, ctl=0/1 in IDLE -> data_error=1 with no frame_start.
- Back-to-back and saturation: frames of 3 and 5 words with a 1-cycle gap -> frame_len 3 then 5. With LEN_WIDTH=4 and a 20-word frame -> frame_len=15, frame_bad=1.
- Mid-frame reset: rst_n=0 on word 7 -> no frame_end; frame_len=0. The next frame is counted from 1.

Source files
------------

// File: rtl/iddr.sv
// rtl/iddr.sv - generic input DDR cell realigning rise/fall samples onto the rising edge
module iddr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);

    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_reg <= '0;
            q1       <= '0;
            q2       <= '0;
        end else begin
            rise_reg <= d;
            q1       <= rise_reg;
            q2       <= fall_reg;
        end
    end

    // Falling-edge half of the pair; q2 picks it up on the next rising edge.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            fall_reg <= '0;
        end else begin
            fall_reg <= d;
        end
    end

endmodule

// File: rtl/iddr_ctl_rx.sv
// rtl/iddr_ctl_rx.sv - DDR receive capture with dv/er decode and frame tracking
module iddr_ctl_rx #(
    parameter int WIDTH     = 4,
    parameter int LEN_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       d,
    input  logic                   ctl,
    output logic [WIDTH-1:0]       q1,
    output logic [WIDTH-1:0]       q2,
    output logic [2*WIDTH-1:0]     data_out,
    output logic                   data_valid,
    output logic                   data_error,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic [LEN_WIDTH-1:0]   frame_len,
    output logic                   frame_bad
);

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_FRAME = 1'b1;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    logic [WIDTH:0]         cap_q1;
    logic [WIDTH:0]         cap_q2;
    logic                   state;
    logic                   state_next;
    logic [LEN_WIDTH-1:0]   count;
    logic                   bad_acc;

    // Control rides as the top bit so it stays aligned with its data pair.
    iddr #(
        .WIDTH (WIDTH + 1)
    ) u_iddr (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({ctl, d}),
        .q1    (cap_q1),
        .q2    (cap_q2)
    );

    assign q1         = cap_q1[WIDTH-1:0];
    assign q2         = cap_q2[WIDTH-1:0];
    assign data_out   = {q2, q1};
    assign data_valid = cap_q1[WIDTH];
    assign data_error = cap_q1[WIDTH] ^ cap_q2[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE:  if (data_valid)  state_next = STATE_FRAME;
            STATE_FRAME: if (!data_valid) state_next = STATE_IDLE;
            default:     state_next = STATE_IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            STATE_IDLE:  frame_start = data_valid;
            STATE_FRAME: frame_end   = !data_valid;
            default:     ;
        endcase
    end

    // Length saturates; an attempted increment past the maximum marks the frame bad.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            bad_acc   <= 1'b0;
            frame_len <= '0;
            frame_bad <= 1'b0;
        end else if (frame_start) begin
            count   <= LEN_WIDTH'(1);
            bad_acc <= data_error;
        end else if (state == STATE_FRAME && data_valid) begin
            bad_acc <= bad_acc | data_error | (count == LEN_MAX);
            if (count != LEN_MAX) begin
                count <= count + LEN_WIDTH'(1);
            end
        end else if (frame_end) begin
            frame_len <= count;
            frame_bad <= bad_acc;
        end
    end

endmodule

// File: tb/tb_iddr_ctl_rx.sv
// tb/tb_iddr_ctl_rx.sv - scoreboard bench for iddr_ctl_rx with a frame-level reference model
module tb_iddr_ctl_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  d = '0;
    logic        ctl = 1'b0;

    logic [3:0]  q1, q2, q1_s, q2_s;
    logic [7:0]  data_out, data_out_s;
    logic        data_valid, data_error, frame_start, frame_end, frame_bad;
    logic        data_valid_s, data_error_s, frame_start_s, frame_end_s, frame_bad_s;
    logic [15:0] frame_len;
    logic [3:0]  frame_len_s;

    iddr_ctl_rx #(.WIDTH(4), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .ctl(ctl),
        .q1(q1), .q2(q2), .data_out(data_out),
        .data_valid(data_valid), .data_error(data_error),
        .frame_start(frame_start), .frame_end(frame_end),
        .frame_len(frame_len), .frame_bad(frame_bad)
    );

    iddr_ctl_rx #(.WIDTH(4), .LEN_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .d(d), .ctl(ctl),
        .q1(q1_s), .q2(q2_s), .data_out(data_out_s),
        .data_valid(data_valid_s), .data_error(data_error_s),
        .frame_start(frame_start_s), .frame_end(frame_end_s),
        .frame_len(frame_len_s), .frame_bad(frame_bad_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [7:0] dout;
        logic       dv, er, st, en;
        logic [15:0] len;
        logic       bad;
        logic [3:0] len4;
        logic       bad4;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    // Reference model state: frame tracked as a plain word count.
    bit          r_prev = 1'b0;
    bit          in_frame = 1'b0;
    int          n_words = 0;
    bit          err_seen = 1'b0;
    logic [15:0] held_len = '0;
    bit          held_bad = 1'b0;
    logic [3:0]  held_len4 = '0;
    bit          held_bad4 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            if (e.tag < cyc) begin
                chk("missed_slot", 32'(e.tag), 32'(cyc));
            end else begin
                chk("data_out",    32'(data_out),    32'(e.dout));
                chk("q1",          32'(q1),          32'(e.dout[3:0]));
                chk("q2",          32'(q2),          32'(e.dout[7:4]));
                chk("data_valid",  32'(data_valid),  32'(e.dv));
                chk("data_error",  32'(data_error),  32'(e.er));
                chk("frame_start", 32'(frame_start), 32'(e.st));
                chk("frame_end",   32'(frame_end),   32'(e.en));
                chk("frame_len",   32'(frame_len),   32'(e.len));
                chk("frame_bad",   32'(frame_bad),   32'(e.bad));
                chk("sat_data_out",   32'(data_out_s),    32'(e.dout));
                chk("sat_frame_start", 32'(frame_start_s), 32'(e.st));
                chk("sat_frame_end",  32'(frame_end_s),   32'(e.en));
                chk("sat_frame_len",  32'(frame_len_s),   32'(e.len4));
                chk("sat_frame_bad",  32'(frame_bad_s),   32'(e.bad4));
            end
        end
    end

    // One DDR pair plus the reset level that applies from the falling edge onward.
    task automatic drive(input logic [3:0] rd, input bit rc, input logic [3:0] fd, input bit fc, input bit rst);
        exp_t x;
        bit dv, er;
        @(negedge clk);
        #1;
        d = rd; ctl = rc;
        @(posedge clk);
        #1;
        d = fd; ctl = fc; rst_n = rst;
        x.tag = cyc + 1;
        if (!rst) begin
            x.dout = '0; dv = 0; er = 0; x.st = 0; x.en = 0;
            in_frame = 0; n_words = 0; err_seen = 0;
            held_len = '0; held_bad = 0; held_len4 = '0; held_bad4 = 0;
            x.len = '0; x.bad = 0; x.len4 = '0; x.bad4 = 0;
        end else begin
            x.dout = {fd, r_prev ? rd : 4'h0};
            dv = r_prev ? rc : 1'b0;
            er = dv ^ fc;
            x.st = dv && !in_frame;
            x.en = !dv && in_frame;
            x.len = held_len; x.bad = held_bad; x.len4 = held_len4; x.bad4 = held_bad4;
            if (dv) begin
                if (!in_frame) begin n_words = 1; err_seen = er; end
                else begin n_words++; err_seen = err_seen | er; end
                in_frame = 1;
            end else if (in_frame) begin
                held_len  = (n_words > 65535) ? 16'hFFFF : 16'(n_words);
                held_bad  = err_seen || (n_words > 65535);
                held_len4 = (n_words > 15) ? 4'hF : 4'(n_words);
                held_bad4 = err_seen || (n_words > 15);
                in_frame = 0;
            end
        end
        x.dv = dv; x.er = er;
        sb.push_back(x);
        r_prev = rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'($urandom), 0, 4'($urandom), 0, 1);
    endtask

    task automatic frame(input int n, input int err_idx);
        for (int i = 0; i < n; i++) drive(4'($urandom), 1, 4'($urandom), (i == err_idx) ? 1'b0 : 1'b1, 1);
    endtask

    initial begin
        int wait_cnt;
        bit rc;
        for (int i = 0; i < 3; i++) drive(4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 0);
        drive(4'h0, 0, 4'h0, 0, 1);
        drive(4'h5, 0, 4'hA, 0, 1);
        drive(4'h3, 0, 4'hC, 0, 1);
        idle(2);
        frame(64, -1);
        idle(2);
        frame(20, 9);
        idle(2);
        drive(4'($urandom), 0, 4'($urandom), 1, 1);
        idle(2);
        frame(3, -1);
        idle(1);
        frame(5, -1);
        idle(2);
        frame(20, -1);
        idle(2);
        frame(6, -1);
        drive(4'($urandom), 1, 4'($urandom), 1, 0);
        drive(4'($urandom), 1, 4'($urandom), 1, 0);
        idle(2);
        frame(4, -1);
        idle(2);
        rc = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) rc = !rc;
            drive(4'($urandom), rc, 4'($urandom), rc ^ ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 79) != 0);
        end
        idle(4);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb.size() > 0) chk("drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
